// File: rtl/countdown_timer.sv
// Two-digit BCD countdown timer with a cycle prescaler and optional auto-reload.
// Define BCD_CHECK_EN to reject loads with a digit above 9 (err pulse) instead of saturating.
module countdown_timer #(
    parameter int unsigned DIV         = 4,
    parameter bit          AUTO_RELOAD = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load_valid,
    input  logic [3:0] load_one,
    input  logic [3:0] load_zero,
    input  logic       start,
    input  logic       pause,
    input  logic       abort,
    output logic       load_ready,
    output logic [3:0] cnt_one,
    output logic [3:0] cnt_zero,
    output logic       busy,
    output logic       done,
    output logic       err
);

    typedef enum logic [1:0] {StIdle, StRun, StHold, StDone} state_e;

    localparam logic [7:0] PrescMax = 8'(DIV - 1);

    state_e     state_q, state_d;
    logic [3:0] cnt_one_q, cnt_one_d;
    logic [3:0] cnt_zero_q, cnt_zero_d;
    logic [3:0] rld_one_q, rld_one_d;
    logic [3:0] rld_zero_q, rld_zero_d;
    logic [7:0] presc_q, presc_d;
    logic       done_q, done_d;
    logic       err_q, err_d;

    logic       load_bad;
    logic [3:0] ld_one, ld_zero;
    logic       cnt_is_zero;

`ifdef BCD_CHECK_EN
    assign load_bad = (load_one > 4'd9) || (load_zero > 4'd9);
    assign ld_one   = load_one;
    assign ld_zero  = load_zero;
`else
    assign load_bad = 1'b0;
    assign ld_one   = (load_one > 4'd9) ? 4'd9 : load_one;
    assign ld_zero  = (load_zero > 4'd9) ? 4'd9 : load_zero;
`endif

    assign cnt_is_zero = (cnt_one_q == 4'd0) && (cnt_zero_q == 4'd0);

    always_comb begin
        state_d    = state_q;
        cnt_one_d  = cnt_one_q;
        cnt_zero_d = cnt_zero_q;
        rld_one_d  = rld_one_q;
        rld_zero_d = rld_zero_q;
        presc_d    = presc_q;
        done_d     = 1'b0;
        err_d      = 1'b0;

        if (abort) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    // A load always wins over a coincident start.
                    if (load_valid) begin
                        if (load_bad) begin
                            err_d = 1'b1;
                        end else begin
                            cnt_one_d  = ld_one;
                            cnt_zero_d = ld_zero;
                            rld_one_d  = ld_one;
                            rld_zero_d = ld_zero;
                            state_d    = StIdle;
                        end
                    end else if (start && (state_q == StIdle)) begin
                        if (cnt_is_zero) begin
                            state_d = StDone;
                            done_d  = 1'b1;
                        end else begin
                            state_d = StRun;
                            presc_d = '0;
                        end
                    end
                end
                StRun: begin
                    if (pause) begin
                        state_d = StHold;
                    end else if (AUTO_RELOAD && cnt_is_zero) begin
                        // 00 was shown for one cycle; restart from the last loaded value.
                        cnt_one_d  = rld_one_q;
                        cnt_zero_d = rld_zero_q;
                        presc_d    = '0;
                    end else if (presc_q == PrescMax) begin
                        presc_d = '0;
                        if (cnt_zero_q == 4'd0) begin
                            cnt_zero_d = 4'd9;
                            cnt_one_d  = cnt_one_q - 4'd1;
                        end else begin
                            cnt_zero_d = cnt_zero_q - 4'd1;
                        end
                        if ((cnt_one_q == 4'd0) && (cnt_zero_q == 4'd1)) begin
                            done_d = 1'b1;
                            if (!AUTO_RELOAD) begin
                                state_d = StDone;
                            end
                        end
                    end else begin
                        presc_d = presc_q + 8'd1;
                    end
                end
                StHold: begin
                    if (!pause) begin
                        state_d = StRun;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            cnt_one_q  <= 4'd0;
            cnt_zero_q <= 4'd0;
            rld_one_q  <= 4'd0;
            rld_zero_q <= 4'd0;
            presc_q    <= 8'd0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_one_q  <= cnt_one_d;
            cnt_zero_q <= cnt_zero_d;
            rld_one_q  <= rld_one_d;
            rld_zero_q <= rld_zero_d;
            presc_q    <= presc_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign load_ready = (state_q == StIdle) || (state_q == StDone);
    assign busy       = (state_q == StRun) || (state_q == StHold);
    assign cnt_one    = cnt_one_q;
    assign cnt_zero   = cnt_zero_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 The block SHALL have parameter DIV, default 4, meaning clock cycles per count step; legal range 1..255.
REQ-002 The block SHALL have parameter AUTO_RELOAD, default 0, meaning 1 = reload the last loaded value and keep running on reaching 00.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset: clk  input  1  rising-edge clock.
REQ-004 reset  input  1  asynchronous active-low reset.
REQ-005 load_valid  input  1  load request.
REQ-006 load_one  input  4  BCD tens digit to load.
REQ-007 load_zero  input  4  BCD ones digit to load.
REQ-008 start  input  1  start countdown.
REQ-009 pause  input  1  level; freeze countdown while high.
REQ-010 abort  input  1  return to IDLE, keep count.
REQ-011 load_ready  output  1  high in IDLE and DONE only.
REQ-012 cnt_one  output  4  current tens digit.
REQ-013 cnt_zero  output  4  current ones digit.
REQ-014 busy  output  1  high in RUN and HOLD.
REQ-015 done  output  1  one-cycle pulse on reaching 00.
REQ-016 err  output  1  one-cycle pulse on a rejected load.

Function
REQ-017 The FSM SHALL have exactly the states IDLE, RUN, HOLD and DONE.
REQ-018 A load_valid while load_ready=1 SHALL capture the digits into cnt_one/cnt_zero and the reload register on the next edge, and the FSM SHALL go to IDLE.
REQ-019 The FSM SHALL ignore load_valid in RUN and HOLD.
REQ-020 In IDLE, start with a nonzero count SHALL go to RUN and clear the prescaler; busy is high from the next cycle.
REQ-021 In IDLE, start with count 00 SHALL go to DONE and pulse done on the next cycle.
REQ-022 If load_valid and start coincide, the load SHALL take effect and start SHALL be ignored.
REQ-023 In RUN, the prescaler SHALL count 0..DIV-1 and decrement the count when it wraps; the first decrement is visible DIV cycles after busy rises.
REQ-024 Decrement SHALL be BCD: if cnt_zero=0, set cnt_zero=9 and decrement cnt_one; otherwise decrement cnt_zero only.
REQ-025 On the decrement that yields 00, done SHALL be high in the same cycle 00 first appears on the outputs.
REQ-026 After that decrement, with AUTO_RELOAD=0 the FSM SHALL enter DONE; with AUTO_RELOAD=1 it SHALL load the reload value on the following edge and stay in RUN with the prescaler cleared.
REQ-027 In RUN, pause=1 SHALL go to HOLD with the prescaler and count frozen; pause=0 SHALL return to RUN and resume the prescaler from its frozen value.
REQ-028 abort SHALL go to IDLE from any state on the next edge, keeping the count; abort overrides start, load_valid and pause.
REQ-029 In DONE, start SHALL be ignored and cnt SHALL hold 00 until a load or abort.

Reset
REQ-030 While reset=0, the block SHALL hold state IDLE, cnt_one=0, cnt_zero=0, reload value 00, prescaler 0, busy=0, done=0, err=0 and load_ready=1, including when reset asserts mid-count.

Configuration
REQ-031 When BCD_CHECK_EN is defined, the block SHALL reject a load with any digit >9: err pulses one cycle, and count, reload value and state stay unchanged.
REQ-032 When BCD_CHECK_EN is not defined, the block SHALL saturate any digit >9 to 9 on load and tie err to 0.

Verification
REQ-033 The bench SHALL cover: DIV=4, load 15, start -> 15,14..10,09..00 each 4 cycles apart; done pulses once with 00; busy low after; state DONE.
REQ-034 The bench SHALL cover: load 20, start, pause high for 7 cycles after the first step -> count holds at 19 for those 7 cycles, then resumes with the remaining prescaler phase.
REQ-035 The bench SHALL cover: AUTO_RELOAD=1, load 02, start -> 01,00(done),02,01,00(done) repeating; busy stays 1.
REQ-036 The bench SHALL cover: load 00, start -> done pulse next cycle; start and load in the same cycle with value 07 -> count 07, state IDLE.
REQ-037 The bench SHALL cover: abort during RUN at count 11 -> IDLE, cnt 11, load_ready 1; reset pulse mid-RUN -> all outputs at reset values immediately.
REQ-038 The bench SHALL cover: load A5 -> with BCD_CHECK_EN, err pulses and cnt is unchanged; without it, cnt becomes 95.
